// File: rtl/leitor_display_bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : leitor_display_bcd_pkg
// Description : Seven-segment definitions shared by the display reader and
//               the board's display-driving decoder: the ten active-low digit
//               patterns, the blank pattern, the special output codes and
//               the frame-assembly state encoding.
//               Segment order is {a,b,c,d,e,f,g}, a = MSB, 0 = segment lit.
// Revision    : 1.0 - initial release
// ============================================================================
package leitor_display_bcd_pkg;

    localparam logic [6:0] c_SEG_0     = 7'b0000001;
    localparam logic [6:0] c_SEG_1     = 7'b1001111;
    localparam logic [6:0] c_SEG_2     = 7'b0010010;
    localparam logic [6:0] c_SEG_3     = 7'b0000110;
    localparam logic [6:0] c_SEG_4     = 7'b1001100;
    localparam logic [6:0] c_SEG_5     = 7'b0100100;
    localparam logic [6:0] c_SEG_6     = 7'b0100000;
    localparam logic [6:0] c_SEG_7     = 7'b0001111;
    localparam logic [6:0] c_SEG_8     = 7'b0000000;
    localparam logic [6:0] c_SEG_9     = 7'b0000100;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    localparam logic [3:0] c_CODE_BLANK = 4'hF;
    localparam logic [3:0] c_CODE_ERR   = 4'hE;

    // Frame-assembly states
    typedef enum logic [1:0] {
        ESPERA = 2'd0,   // no digit captured yet
        COLETA = 2'd1,   // some digits captured
        CHEIO  = 2'd2    // every digit captured, waiting for the output slot
    } estado_t;

endpackage : leitor_display_bcd_pkg
`default_nettype wire

// File: rtl/seg7_para_bcd.sv
`default_nettype none
// ============================================================================
// Module      : seg7_para_bcd
// Description : Combinational lookup from an active-low 7-segment pattern to
//               a BCD code. Blank maps to CODE_BLANK and is not an error;
//               any unknown pattern maps to CODE_ERR with o_invalid set.
// Ports       : i_seg     [6:0] pattern {a..g}, 0 = lit
//               o_code    [3:0] recovered code
//               o_invalid       pattern is neither a digit nor blank
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_para_bcd
    import leitor_display_bcd_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_code,
    output logic       o_invalid
);

    always_comb begin
        o_code    = c_CODE_ERR;
        o_invalid = 1'b1;
        case (i_seg)
            c_SEG_0:     begin o_code = 4'd0;         o_invalid = 1'b0; end
            c_SEG_1:     begin o_code = 4'd1;         o_invalid = 1'b0; end
            c_SEG_2:     begin o_code = 4'd2;         o_invalid = 1'b0; end
            c_SEG_3:     begin o_code = 4'd3;         o_invalid = 1'b0; end
            c_SEG_4:     begin o_code = 4'd4;         o_invalid = 1'b0; end
            c_SEG_5:     begin o_code = 4'd5;         o_invalid = 1'b0; end
            c_SEG_6:     begin o_code = 4'd6;         o_invalid = 1'b0; end
            c_SEG_7:     begin o_code = 4'd7;         o_invalid = 1'b0; end
            c_SEG_8:     begin o_code = 4'd8;         o_invalid = 1'b0; end
            c_SEG_9:     begin o_code = 4'd9;         o_invalid = 1'b0; end
            c_SEG_BLANK: begin o_code = c_CODE_BLANK; o_invalid = 1'b0; end
            default:     begin o_code = c_CODE_ERR;   o_invalid = 1'b1; end
        endcase
    end

endmodule : seg7_para_bcd
`default_nettype wire

// File: rtl/leitor_display_bcd.sv
`default_nettype none
// ============================================================================
// Module      : leitor_display_bcd
// Description : Reads a time-multiplexed active-low 7-segment display bus,
//               filters each digit's pattern for stability, recovers the BCD
//               code and delivers complete frames on a valid/ready port.
// Ports       : clk        clock, rising edge
//               rst_n      synchronous active-low reset
//               seg_in     [6:0] segments {a..g}, 0 = lit (asynchronous)
//               an_in      [DIGITS-1:0] digit enables, active-low one-hot
//               out_valid  frame available
//               out_ready  consumer accepts on out_valid && out_ready
//               bcd_out    [4*DIGITS-1:0] digit i at [4i+3:4i]
//               err_out    frame contained an invalid pattern
//               overrun    one-cycle pulse, a commit was discarded
// Revision    : 1.0 - initial release
// ============================================================================
module leitor_display_bcd
    import leitor_display_bcd_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  err_out,
    output logic                  overrun
);

    localparam int                c_CW      = $clog2(STABLE_CYCLES + 1);
    localparam int                c_SW      = DIGITS + 7;
    localparam logic [c_CW-1:0]   c_CNT_MAX = c_CW'(STABLE_CYCLES);

    // Two-flop synchronizers
    logic [6:0]          r_seg_s1, r_seg_s2;
    logic [DIGITS-1:0]   r_an_s1,  r_an_s2;

    // Stability filter
    logic [c_SW-1:0]     w_s;
    logic [c_SW-1:0]     r_s_prev;
    logic [c_CW-1:0]     r_cnt;
    logic                r_done;

    // Frame assembly
    logic [DIGITS-1:0]   r_mask;
    logic [4*DIGITS-1:0] r_shadow;
    logic                r_frame_err;
    estado_t             r_state, w_state_next;

    // Output register
    logic                r_out_valid;
    logic [4*DIGITS-1:0] r_bcd_out;
    logic                r_err_out;
    logic                r_overrun;

    logic [DIGITS-1:0]   w_an_sel;
    logic                w_onehot;
    logic                w_commit;
    logic                w_accept;
    logic                w_fills;
    logic                w_load;
    logic                w_overrun;
    logic [3:0]          w_code;
    logic                w_invalid;

    seg7_para_bcd u_dec (
        .i_seg     (r_seg_s2),
        .o_code    (w_code),
        .o_invalid (w_invalid)
    );

    assign w_s      = {r_an_s2, r_seg_s2};
    assign w_an_sel = ~r_an_s2;
    // Exactly one digit enabled: non-zero with a single bit set
    assign w_onehot = (w_an_sel != '0) &&
                      ((w_an_sel & (w_an_sel - DIGITS'(1))) == '0);
    // r_done limits a stable run to a single commit
    assign w_commit = (r_cnt == c_CNT_MAX) && !r_done && w_onehot && (w_s == r_s_prev);
    // Commits arriving while the frame buffer is full are dropped
    assign w_accept = w_commit && (r_state != CHEIO);
    assign w_fills  = ((r_mask | w_an_sel) == '1);

    // ------------------------------------------------------------------
    // Synchronizers and stability filter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg_s1 <= '0;
            r_seg_s2 <= '0;
            r_an_s1  <= '0;
            r_an_s2  <= '0;
            r_s_prev <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_seg_s1 <= seg_in;
            r_seg_s2 <= r_seg_s1;
            r_an_s1  <= an_in;
            r_an_s2  <= r_an_s1;
            r_s_prev <= w_s;
            if (w_s != r_s_prev) begin
                r_cnt  <= c_CW'(1);
                r_done <= 1'b0;
            end else begin
                if (r_cnt != c_CNT_MAX) begin
                    r_cnt <= r_cnt + c_CW'(1);
                end
                if (w_commit) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame assembly FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ESPERA;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame assembly FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_overrun    = 1'b0;
        case (r_state)
            ESPERA: begin
                if (w_commit) begin
                    w_state_next = w_fills ? CHEIO : COLETA;
                end
            end
            COLETA: begin
                if (w_commit && w_fills) begin
                    w_state_next = CHEIO;
                end
            end
            CHEIO: begin
                w_overrun = w_commit;
                // Output slot free, or being emptied on this same edge
                if (!r_out_valid || out_ready) begin
                    w_load       = 1'b1;
                    w_state_next = ESPERA;
                end
            end
            default: begin
                w_state_next = ESPERA;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow frame, digit mask and accumulated error
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow    <= '0;
            r_mask      <= '0;
            r_frame_err <= 1'b0;
        end else if (w_load) begin
            r_mask      <= '0;
            r_frame_err <= 1'b0;
        end else if (w_accept) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (w_an_sel[i]) begin
                    r_shadow[4*i +: 4] <= w_code;
                end
            end
            r_mask      <= r_mask | w_an_sel;
            r_frame_err <= r_frame_err | w_invalid;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_bcd_out   <= '0;
            r_err_out   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= w_overrun;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_bcd_out   <= r_shadow;
                r_err_out   <= r_frame_err;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign bcd_out   = r_bcd_out;
    assign err_out   = r_err_out;
    assign overrun   = r_overrun;

endmodule : leitor_display_bcd
`default_nettype wire

// File: tb/tb_leitor_display_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_leitor_display_bcd
// Description : Directed self-checking bench for leitor_display_bcd. Expected
//               frames are queued when their digits are driven and compared
//               when the DUT hands the frame over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_leitor_display_bcd;

    localparam int DIGITS        = 4;
    localparam int STABLE_CYCLES = 4;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] bcd_out;
    logic        err_out;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;
    int ov_seen = 0;

    logic [16:0] sb[$];          // {err, bcd}
    logic [6:0]  segtab [10];

    leitor_display_bcd #(
        .DIGITS        (DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .an_in     (an_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .err_out   (err_out),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: a handshake seen at the negedge completes on the next posedge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_frame", {15'd0, err_out, bcd_out}, 32'h1FFFF);
            end else begin
                logic [16:0] e;
                e = sb.pop_front();
                check("frame_bcd", {16'd0, bcd_out}, {16'd0, e[15:0]});
                check("frame_err", {31'd0, err_out}, {31'd0, e[16]});
            end
        end
        if (rst_n && overrun) ov_seen++;
    end

    // All drivers start and end just after a rising edge
    task automatic drive(input int d, input logic [6:0] p, input int hold);
        logic [3:0] a;
        a = 4'b1111;
        a[d] = 1'b0;
        an_in  = a;
        seg_in = p;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        an_in  = 4'b1111;
        seg_in = 7'b1111111;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 40; k++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
        end
        check(tag, {31'd0, out_valid}, 32'd1);
        idle(2);
    endtask

    initial begin
        int ov_base;
        segtab[0] = 7'b0000001; segtab[1] = 7'b1001111; segtab[2] = 7'b0010010;
        segtab[3] = 7'b0000110; segtab[4] = 7'b1001100; segtab[5] = 7'b0100100;
        segtab[6] = 7'b0100000; segtab[7] = 7'b0001111; segtab[8] = 7'b0000000;
        segtab[9] = 7'b0000100;

        rst_n     = 1'b0;
        out_ready = 1'b1;
        an_in     = 4'b1111;
        seg_in    = 7'b1111111;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",   {31'd0, out_valid}, 32'd0);
        check("rst_bcd",     {16'd0, bcd_out},   32'd0);
        check("rst_err",     {31'd0, err_out},   32'd0);
        check("rst_overrun", {31'd0, overrun},   32'd0);
        rst_n = 1'b1;
        idle(3);

        // Basic frame 1,9,8,4 with latency check on the last digit
        sb.push_back({1'b0, 16'h4891});
        drive(0, segtab[1], 8);
        drive(1, segtab[9], 8);
        drive(2, segtab[8], 8);
        an_in  = 4'b0111;
        seg_in = segtab[4];
        repeat (STABLE_CYCLES + 3) @(posedge clk);
        #1;
        check("lat_before", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_at", {31'd0, out_valid}, 32'd1);
        idle(4);
        check("lat_drop", {31'd0, out_valid}, 32'd0);

        // Invalid and blank digits, plus an overwritten digit 0 (3 then 0)
        sb.push_back({1'b1, 16'hFE50});
        drive(0, segtab[3], 8);
        drive(0, segtab[0], 8);
        drive(1, segtab[5], 8);
        drive(2, 7'b1111110, 8);
        drive(3, 7'b1111111, 8);
        wait_valid("err_frame_valid");

        // Clean frame after the error frame
        sb.push_back({1'b0, 16'h7632});
        drive(0, segtab[2], 8);
        drive(1, segtab[3], 8);
        drive(2, segtab[6], 8);
        drive(3, segtab[7], 8);
        wait_valid("clean_frame_valid");

        // Glitch: one cycle short of the commit window on digit 0
        drive(0, segtab[7], STABLE_CYCLES);
        idle(10);
        drive(1, segtab[1], 8);
        drive(2, segtab[2], 8);
        drive(3, segtab[3], 8);
        idle(6);
        check("glitch_no_commit", {31'd0, out_valid}, 32'd0);

        // Two or zero digits enabled must never commit
        an_in  = 4'b1100;
        seg_in = segtab[5];
        repeat (20) @(posedge clk);
        #1;
        an_in = 4'b1111;
        repeat (20) @(posedge clk);
        #1;
        idle(4);
        check("bad_an_no_commit", {31'd0, out_valid}, 32'd0);
        sb.push_back({1'b0, 16'h3210});
        drive(0, segtab[0], 8);
        wait_valid("after_glitch_valid");

        // Reset mid-frame discards committed digits
        drive(0, segtab[1], 8);
        drive(1, segtab[2], 8);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_bcd",   {16'd0, bcd_out},   32'd0);
        drive(2, segtab[5], 8);
        drive(3, segtab[6], 8);
        idle(6);
        check("midrst_incomplete", {31'd0, out_valid}, 32'd0);
        sb.push_back({1'b0, 16'h6587});
        drive(0, segtab[7], 8);
        drive(1, segtab[8], 8);
        wait_valid("midrst_frame_valid");

        // Back-pressure: held first frame, second waits full, overrun on extra commit
        out_ready = 1'b0;
        sb.push_back({1'b0, 16'h4321});
        drive(0, segtab[1], 8);
        drive(1, segtab[2], 8);
        drive(2, segtab[3], 8);
        drive(3, segtab[4], 8);
        idle(4);
        check("bp_first_valid", {31'd0, out_valid}, 32'd1);
        check("bp_first_bcd",   {16'd0, bcd_out},   32'h4321);
        sb.push_back({1'b0, 16'h8765});
        ov_base = ov_seen;
        drive(0, segtab[5], 8);
        drive(1, segtab[6], 8);
        drive(2, segtab[7], 8);
        drive(3, segtab[8], 8);
        idle(4);
        check("bp_no_overrun", ov_seen - ov_base, 32'd0);
        check("bp_held_bcd",   {16'd0, bcd_out},  32'h4321);
        drive(0, segtab[9], 8);
        idle(2);
        check("bp_overrun", ov_seen - ov_base, 32'd1);
        check("bp_still_held", {16'd0, bcd_out}, 32'h4321);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_same_edge_valid", {31'd0, out_valid}, 32'd1);
        check("bp_same_edge_bcd",   {16'd0, bcd_out},   32'h8765);
        @(posedge clk);
        #1;
        check("bp_drained", {31'd0, out_valid}, 32'd0);
        idle(2);
        check("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_leitor_display_bcd
`default_nettype wire
